// File: rtl/move_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : move_link_ctrl
// Brief    : Serial move-link sequencer between two boards. Sends local moves
//            and retransmits them until the peer ACKs, delivers peer moves
//            and ACKs them, and shares the single tx channel between both.
// Options  : DUP_FILTER_EN - when defined, a repeated peer move (same byte as
//            the last delivered one) is re-ACKed without a peer_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module move_link_ctrl #(
   parameter int                 PKT_LEN     = 8,
   parameter logic [PKT_LEN-1:0] ACK_CODE    = 8'hFF,
   parameter int                 TIMEOUT_CYC = 6_500_000,
   parameter int                 MAX_RETRY   = 3
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               local_valid,
   input  logic [PKT_LEN-1:0] local_move,
   output logic               local_ready,
   input  logic               rx_ready,
   input  logic [PKT_LEN-1:0] rx_data,
   input  logic               tx_busy,
   output logic               tx_trigger,
   output logic [PKT_LEN-1:0] tx_data,
   output logic               peer_valid,
   output logic [PKT_LEN-1:0] peer_move,
   output logic               link_err,
   output logic [2:0]         state
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] C_TMR_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] C_RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SEND     = 3'd1,
      S_WAIT_ACK = 3'd2,
      S_SEND_ACK = 3'd3,
      S_ERROR    = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic               tx_trigger_q, tx_trigger_d;
   logic [PKT_LEN-1:0] tx_data_q, tx_data_d;
   logic               peer_valid_q, peer_valid_d;
   logic [PKT_LEN-1:0] peer_move_q, peer_move_d;
   logic               link_err_q, link_err_d;
   logic [RW-1:0]      retry_q, retry_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               pending_q, pending_d;
   logic [PKT_LEN-1:0] move_q, move_d;

   logic w_rx_ack;
   logic w_rx_move;
   logic w_local_ok;
   logic w_tx_free;
   logic w_dup;

   assign w_rx_ack   = rx_ready && (rx_data == ACK_CODE);
   assign w_rx_move  = rx_ready && (rx_data != ACK_CODE);
   assign w_local_ok = local_valid && local_ready;
   // The trigger just issued has not yet been reflected in tx_busy, so the
   // cycle right after a trigger is never considered free.
   assign w_tx_free  = !tx_busy && !tx_trigger_q;

`ifdef DUP_FILTER_EN
   logic delivered_q;

   // Remembers that peer_move holds a real delivered move (not the reset 0).
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)            delivered_q <= 1'b0;
      else if (peer_valid_d) delivered_q <= 1'b1;
   end

   assign w_dup = delivered_q && (rx_data == peer_move_q);
`else
   assign w_dup = 1'b0;
`endif

   assign local_ready = (state_q == S_IDLE) && !pending_q;
   assign tx_trigger  = tx_trigger_q;
   assign tx_data     = tx_data_q;
   assign peer_valid  = peer_valid_q;
   assign peer_move   = peer_move_q;
   assign link_err    = link_err_q;
   assign state       = state_q;

   // State and output registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= S_IDLE;
         tx_trigger_q <= 1'b0;
         tx_data_q    <= '0;
         peer_valid_q <= 1'b0;
         peer_move_q  <= '0;
         link_err_q   <= 1'b0;
         retry_q      <= '0;
         timer_q      <= '0;
         pending_q    <= 1'b0;
         move_q       <= '0;
      end else begin
         state_q      <= state_d;
         tx_trigger_q <= tx_trigger_d;
         tx_data_q    <= tx_data_d;
         peer_valid_q <= peer_valid_d;
         peer_move_q  <= peer_move_d;
         link_err_q   <= link_err_d;
         retry_q      <= retry_d;
         timer_q      <= timer_d;
         pending_q    <= pending_d;
         move_q       <= move_d;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_d      = state_q;
      tx_trigger_d = 1'b0;
      tx_data_d    = tx_data_q;
      peer_valid_d = 1'b0;
      peer_move_d  = peer_move_q;
      link_err_d   = link_err_q;
      retry_d      = retry_q;
      timer_d      = timer_q;
      pending_d    = pending_q;
      move_d       = move_q;

      case (state_q)
         S_IDLE: begin
            if (w_rx_move) begin
               // Incoming move has priority; a simultaneous local move waits.
               if (!w_dup) begin
                  peer_valid_d = 1'b1;
                  peer_move_d  = rx_data;
               end
               if (w_local_ok) begin
                  move_d    = local_move;
                  pending_d = 1'b1;
               end
               state_d = S_SEND_ACK;
            end else if (w_local_ok) begin
               move_d  = local_move;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            if (w_tx_free) begin
               tx_trigger_d = 1'b1;
               tx_data_d    = move_q;
               timer_d      = '0;
               state_d      = S_WAIT_ACK;
            end
         end

         S_WAIT_ACK: begin
            if (w_rx_ack) begin
               retry_d   = '0;
               pending_d = 1'b0;
               timer_d   = '0;
               state_d   = S_IDLE;
            end else if (timer_q == C_TMR_LAST) begin
               if (retry_q < C_RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_SEND;
               end else begin
                  link_err_d = 1'b1;
                  state_d    = S_ERROR;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_SEND_ACK: begin
            if (w_tx_free) begin
               tx_trigger_d = 1'b1;
               tx_data_d    = ACK_CODE;
               state_d      = pending_q ? S_SEND : S_IDLE;
            end
         end

         S_ERROR: begin
            link_err_d = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_move_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_link_ctrl
// Brief    : Self-checking bench for move_link_ctrl. A transaction-level
//            scoreboard predicts the bytes sent on tx and the moves delivered
//            to game_fsm; a tx model drives tx_busy after each trigger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_link_ctrl;

   localparam int         T_CYC   = 100;
   localparam int         N_RETRY = 3;
   localparam logic [7:0] ACK     = 8'hFF;
`ifdef DUP_FILTER_EN
   localparam bit DUP = 1'b1;
`else
   localparam bit DUP = 1'b0;
`endif

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       local_valid;
   logic [7:0] local_move;
   logic       local_ready;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       tx_busy;
   logic       tx_trigger;
   logic [7:0] tx_data;
   logic       peer_valid;
   logic [7:0] peer_move;
   logic       link_err;
   logic [2:0] state;

   move_link_ctrl #(
      .PKT_LEN     (8),
      .ACK_CODE    (8'hFF),
      .TIMEOUT_CYC (T_CYC),
      .MAX_RETRY   (N_RETRY)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .local_valid (local_valid),
      .local_move  (local_move),
      .local_ready (local_ready),
      .rx_ready    (rx_ready),
      .rx_data     (rx_data),
      .tx_busy     (tx_busy),
      .tx_trigger  (tx_trigger),
      .tx_data     (tx_data),
      .peer_valid  (peer_valid),
      .peer_move   (peer_move),
      .link_err    (link_err),
      .state       (state)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // Observed traffic and scoreboard expectations.
   logic [7:0] trig_data[$];
   int         trig_cyc[$];
   logic [7:0] pv_seen[$];
   logic [7:0] exp_tx[$];
   logic [7:0] exp_pv[$];
   bit         m_deliv;
   logic [7:0] m_last;

   int busy_len = 4;
   int busy_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // tx UART model: every trigger is logged and makes tx busy for busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk_in);
         if (busy_cnt > 0) busy_cnt--;
         if (tx_trigger === 1'b1) begin
            chk("trigger_while_busy", tx_busy, 1'b0);
            trig_data.push_back(tx_data);
            trig_cyc.push_back(cyc);
            busy_cnt = busy_len;
         end
         tx_busy = (busy_cnt > 0);
      end
   end

   // game_fsm side: log every delivered move.
   initial begin
      forever begin
         @(negedge clk_in);
         if (peer_valid === 1'b1) pv_seen.push_back(peer_move);
      end
   end

   // Watchdog.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] rand_move();
      return 8'($urandom_range(0, 254));
   endfunction

   // Reference rule for a peer move arriving in IDLE.
   function automatic void model_peer(input logic [7:0] p);
      if (!(DUP && m_deliv && p == m_last)) begin
         exp_pv.push_back(p);
         m_last  = p;
         m_deliv = 1'b1;
      end
      exp_tx.push_back(ACK);
   endfunction

   task automatic step();
      @(negedge clk_in);
      #1;
   endtask

   task automatic pulse_rx(input logic [7:0] d);
      step();
      rx_ready = 1'b1;
      rx_data  = d;
      step();
      rx_ready = 1'b0;
   endtask

   task automatic pulse_local(input logic [7:0] d);
      step();
      local_valid = 1'b1;
      local_move  = d;
      step();
      local_valid = 1'b0;
   endtask

   task automatic clear_all();
      trig_data.delete();
      trig_cyc.delete();
      pv_seen.delete();
      exp_tx.delete();
      exp_pv.delete();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_state"},       state,       3'd0);
      chk({tag, "_tx_trigger"},  tx_trigger,  1'b0);
      chk({tag, "_tx_data"},     tx_data,     8'h00);
      chk({tag, "_peer_valid"},  peer_valid,  1'b0);
      chk({tag, "_peer_move"},   peer_move,   8'h00);
      chk({tag, "_link_err"},    link_err,    1'b0);
      chk({tag, "_local_ready"}, local_ready, 1'b1);
   endtask

   task automatic apply_reset(input string tag);
      step();
      rst_in = 1'b1;
      #1;
      check_reset(tag);
      repeat (3) step();
      rst_in  = 1'b0;
      m_deliv = 1'b0;
      m_last  = 8'h00;
      clear_all();
   endtask

   task automatic wait_trigs(input string tag, input int n, input int budget);
      int k = 0;
      while (trig_data.size() < n && k < budget) begin
         step();
         k++;
      end
      chk({tag, "_trigger_timeout"}, (trig_data.size() >= n), 1'b1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (state !== 3'd0 && k < budget) begin
         step();
         k++;
      end
      chk({tag, "_idle_timeout"}, state, 3'd0);
   endtask

   task automatic check_queues(input string tag);
      chk({tag, "_n_tx"}, trig_data.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size() && i < trig_data.size(); i++)
         chk({tag, "_tx_byte"}, trig_data[i], exp_tx[i]);
      chk({tag, "_n_peer"}, pv_seen.size(), exp_pv.size());
      for (int i = 0; i < exp_pv.size() && i < pv_seen.size(); i++)
         chk({tag, "_peer_byte"}, pv_seen[i], exp_pv[i]);
      clear_all();
   endtask

   initial begin
      logic [7:0] m;
      int         d;
      rst_in      = 1'b1;
      local_valid = 1'b0;
      local_move  = 8'h00;
      rx_ready    = 1'b0;
      rx_data     = 8'h00;
      m_deliv     = 1'b0;
      m_last      = 8'h00;

      // Reset values.
      apply_reset("reset");

      // Local move: trigger two edges after local_valid, then ACK returns to IDLE.
      busy_len = 4;
      step();
      local_valid = 1'b1;
      local_move  = 8'h23;
      @(posedge clk_in); #1;
      local_valid = 1'b0;
      chk("lat_state_send", state, 3'd1);
      chk("lat_not_ready", local_ready, 1'b0);
      chk("lat_no_early_trigger", tx_trigger, 1'b0);
      @(posedge clk_in); #1;
      chk("lat_trigger", tx_trigger, 1'b1);
      chk("lat_tx_data", tx_data, 8'h23);
      chk("lat_state_wait", state, 3'd2);
      exp_tx.push_back(8'h23);
      repeat (40) step();
      pulse_rx(ACK);
      wait_idle("t1", 20);
      chk("t1_ready", local_ready, 1'b1);
      repeat (10) step();
      check_queues("t1");

      // Stray ACK in IDLE is dropped.
      pulse_rx(ACK);
      repeat (10) step();
      chk("stray_state", state, 3'd0);
      check_queues("stray");

      // Peer move: delivered once, then answered with ACK.
      pulse_rx(8'h45);
      model_peer(8'h45);
      repeat (20) step();
      chk("peer_move_held", peer_move, 8'h45);
      chk("peer_tx_data_held", tx_data, ACK);
      check_queues("t3");

      // Same peer move twice (after reset so no earlier delivery exists).
      apply_reset("rst_dup");
      pulse_rx(8'h45);
      model_peer(8'h45);
      repeat (20) step();
      pulse_rx(8'h45);
      model_peer(8'h45);
      repeat (20) step();
      check_queues("t5");

      // Local move and peer move in the same cycle: ACK first, then the move.
      busy_len = 6;
      step();
      local_valid = 1'b1;
      local_move  = 8'h11;
      rx_ready    = 1'b1;
      rx_data     = 8'h46;
      step();
      local_valid = 1'b0;
      rx_ready    = 1'b0;
      model_peer(8'h46);
      exp_tx.push_back(8'h11);
      wait_trigs("t4", 2, 100);
      repeat (3) step();
      pulse_rx(ACK);
      wait_idle("t4", 30);
      repeat (12) step();
      check_queues("t4");

      // Randomized traffic; busy input and ignored inputs mixed in.
      for (int k = 0; k < 10; k++) begin
         busy_len = $urandom_range(1, 10);
         if ($urandom_range(0, 1) == 1) begin
            m = rand_move();
            pulse_local(m);
            exp_tx.push_back(m);
            wait_trigs("rnd", 1, 30);
            pulse_local(rand_move());   // not ready: ignored
            pulse_rx(rand_move());      // non-ACK while waiting: dropped
            d = $urandom_range(2, 60);
            repeat (d) step();
            pulse_rx(ACK);
            wait_idle("rnd", 30);
         end else begin
            m = rand_move();
            pulse_rx(m);
            model_peer(m);
         end
         repeat (14) step();
         chk("rnd_state", state, 3'd0);
         chk("rnd_ready", local_ready, 1'b1);
         check_queues("rnd");
      end

      // No ACK: first send plus N_RETRY retries, T_CYC+1 cycles apart, then ERROR.
      apply_reset("rst_retry");
      busy_len = 5;
      pulse_local(8'h23);
      wait_trigs("t2", N_RETRY + 1, (N_RETRY + 1) * (T_CYC + 1) + 50);
      chk("t2_n_trig", trig_data.size(), N_RETRY + 1);
      for (int i = 0; i < trig_data.size(); i++) begin
         chk("t2_byte", trig_data[i], 8'h23);
         if (i > 0) chk("t2_spacing", trig_cyc[i] - trig_cyc[i-1], T_CYC + 1);
      end
      repeat (T_CYC + 10) step();
      chk("t2_state_err", state, 3'd4);
      chk("t2_link_err", link_err, 1'b1);
      chk("t2_not_ready", local_ready, 1'b0);
      pulse_rx(8'h45);
      pulse_local(8'h12);
      pulse_rx(ACK);
      repeat (20) step();
      chk("t2_n_trig_after", trig_data.size(), N_RETRY + 1);
      chk("t2_no_peer", pv_seen.size(), 0);
      chk("t2_still_err", state, 3'd4);
      chk("t2_err_sticky", link_err, 1'b1);

      // Reset while waiting for ACK with tx busy: immediate abort, silent after.
      apply_reset("rst_abort_pre");
      busy_len = 10;
      pulse_local(8'h5A);
      wait_trigs("t6", 1, 20);
      repeat (2) step();
      chk("t6_setup_busy", tx_busy, 1'b1);
      chk("t6_setup_wait", state, 3'd2);
      rst_in = 1'b1;
      #1;
      check_reset("t6_abort");
      repeat (3) step();
      rst_in = 1'b0;
      m_deliv = 1'b0;
      m_last  = 8'h00;
      clear_all();
      repeat (3 * T_CYC) step();
      chk("t6_state", state, 3'd0);
      check_queues("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
